// File: rtl/static_axil_master.sv
// Single-outstanding AXI-Lite master driven by a simple command/response port.
// Optional watchdog enabled by defining STATIC_AXIL_TIMEOUT_EN.
module static_axil_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                CLK_IN_125M,
  input  logic                AXI_RESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   M_AXI_LITE_awaddr,
  output logic [2:0]          M_AXI_LITE_awprot,
  output logic                M_AXI_LITE_awvalid,
  input  logic                M_AXI_LITE_awready,
  output logic [DATA_W-1:0]   M_AXI_LITE_wdata,
  output logic [DATA_W/8-1:0] M_AXI_LITE_wstrb,
  output logic                M_AXI_LITE_wvalid,
  input  logic                M_AXI_LITE_wready,
  input  logic [1:0]          M_AXI_LITE_bresp,
  input  logic                M_AXI_LITE_bvalid,
  output logic                M_AXI_LITE_bready,
  output logic [ADDR_W-1:0]   M_AXI_LITE_araddr,
  output logic [2:0]          M_AXI_LITE_arprot,
  output logic                M_AXI_LITE_arvalid,
  input  logic                M_AXI_LITE_arready,
  input  logic [DATA_W-1:0]   M_AXI_LITE_rdata,
  input  logic [1:0]          M_AXI_LITE_rresp,
  input  logic                M_AXI_LITE_rvalid,
  output logic                M_AXI_LITE_rready
);

  if (TIMEOUT_CYCLES < 1 || (DATA_W % 8) != 0) begin : g_param_check
    $error("static_axil_master: invalid TIMEOUT_CYCLES or DATA_W");
  end

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              aw_pend, w_pend;
  logic              cmd_hs, aw_hs, w_hs, b_hs, r_hs;
  logic              timeout;
  logic              beat_en;

`ifdef STATIC_AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             busy;
  logic             hung;

  assign busy    = (state == WR) || (state == WR_RESP) || (state == RD_ADDR) || (state == RD_DATA);
  assign timeout = busy && (wd_cnt == CNT_W'(TIMEOUT_CYCLES));
  // After a timeout the slave may still owe a beat; never accept it until reset.
  assign beat_en = !hung;

  always_ff @(posedge CLK_IN_125M) begin
    if (AXI_RESET) begin
      wd_cnt <= '0;
      hung   <= 1'b0;
    end else begin
      if (busy && !timeout) wd_cnt <= wd_cnt + CNT_W'(1);
      else                  wd_cnt <= '0;
      if (timeout) hung <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign beat_en = 1'b1;
`endif

  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_hs  = M_AXI_LITE_awvalid && M_AXI_LITE_awready;
  assign w_hs   = M_AXI_LITE_wvalid && M_AXI_LITE_wready;
  assign b_hs   = M_AXI_LITE_bvalid && M_AXI_LITE_bready;
  assign r_hs   = M_AXI_LITE_rvalid && M_AXI_LITE_rready;

  assign M_AXI_LITE_awaddr = addr_q;
  assign M_AXI_LITE_araddr = addr_q;
  assign M_AXI_LITE_wdata  = wdata_q;
  assign M_AXI_LITE_wstrb  = '1;
  assign M_AXI_LITE_awprot = '0;
  assign M_AXI_LITE_arprot = '0;

  always_ff @(posedge CLK_IN_125M) begin
    if (AXI_RESET) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_hs) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        aw_pend <= cmd_write;
        w_pend  <= cmd_write;
      end
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= M_AXI_LITE_bresp;
      end
      if (r_hs) begin
        rsp_rdata <= M_AXI_LITE_rdata;
        rsp_resp  <= M_AXI_LITE_rresp;
      end
      if (timeout) begin
        rsp_rdata <= '0;
        rsp_resp  <= 2'b11;
      end
    end
  end

  // WR exits on the registered pending flags, so both handshakes are already
  // retired (same-cycle or not) before bready can rise.
  always_comb begin
    state_nxt          = state;
    cmd_ready          = 1'b0;
    rsp_valid          = 1'b0;
    M_AXI_LITE_awvalid = 1'b0;
    M_AXI_LITE_wvalid  = 1'b0;
    M_AXI_LITE_bready  = 1'b0;
    M_AXI_LITE_arvalid = 1'b0;
    M_AXI_LITE_rready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !AXI_RESET;
        if (cmd_valid && !AXI_RESET) state_nxt = cmd_write ? WR : RD_ADDR;
      end
      WR: begin
        M_AXI_LITE_awvalid = aw_pend;
        M_AXI_LITE_wvalid  = w_pend;
        if (!aw_pend && !w_pend) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        M_AXI_LITE_bready = beat_en;
        if (M_AXI_LITE_bvalid && beat_en) state_nxt = RSP;
      end
      RD_ADDR: begin
        M_AXI_LITE_arvalid = 1'b1;
        if (M_AXI_LITE_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_LITE_rready = beat_en;
        if (M_AXI_LITE_rvalid && beat_en) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      M_AXI_LITE_awvalid = 1'b0;
      M_AXI_LITE_wvalid  = 1'b0;
      M_AXI_LITE_bready  = 1'b0;
      M_AXI_LITE_arvalid = 1'b0;
      M_AXI_LITE_rready  = 1'b0;
      state_nxt          = RSP;
    end
  end

endmodule

// File: tb/tb_static_axil_master.sv
// Directed self-checking bench for static_axil_master; inputs driven and
// outputs sampled on the falling clock edge.
module tb_static_axil_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  static_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .CLK_IN_125M(clk), .AXI_RESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_LITE_awaddr(awaddr), .M_AXI_LITE_awprot(awprot), .M_AXI_LITE_awvalid(awvalid),
    .M_AXI_LITE_awready(awready),
    .M_AXI_LITE_wdata(wdata), .M_AXI_LITE_wstrb(wstrb), .M_AXI_LITE_wvalid(wvalid),
    .M_AXI_LITE_wready(wready),
    .M_AXI_LITE_bresp(bresp), .M_AXI_LITE_bvalid(bvalid), .M_AXI_LITE_bready(bready),
    .M_AXI_LITE_araddr(araddr), .M_AXI_LITE_arprot(arprot), .M_AXI_LITE_arvalid(arvalid),
    .M_AXI_LITE_arready(arready),
    .M_AXI_LITE_rdata(rdata), .M_AXI_LITE_rresp(rresp), .M_AXI_LITE_rvalid(rvalid),
    .M_AXI_LITE_rready(rready)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    tick(3);
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_ready: got %0b want 0", cmd_ready); end
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
      n_errors++; $display("FAIL reset_valids: got %b want 000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
    end
    n_checks++;
    if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      n_errors++; $display("FAIL reset_rsp: got %b/%h want 00/00000000", rsp_resp, rsp_rdata);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready: got %0b want 1", cmd_ready); end
    tick();
  endtask

  task automatic test_write_zero_wait;
    awready = 1'b1; wready = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hCAFE0001;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL wr_cmd_ready: got %0b want 1", cmd_ready); end
    tick(); cmd_valid = 1'b0;
    n_checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
      n_errors++; $display("FAIL wr_valids_rise: got aw=%0b w=%0b want 1/1", awvalid, wvalid);
    end
    n_checks++;
    if (awaddr !== 32'h10 || wdata !== 32'hCAFE0001 || wstrb !== 4'hF || awprot !== 3'b000) begin
      n_errors++; $display("FAIL wr_fields: got %h %h %h %b want 10 cafe0001 f 000", awaddr, wdata, wstrb, awprot);
    end
    tick();
    n_checks++;
    if ({awvalid, wvalid, bready} !== 3'b000) begin
      n_errors++; $display("FAIL wr_after_hs: got %b want 000", {awvalid, wvalid, bready});
    end
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    n_checks++;
    if (bready !== 1'b1) begin n_errors++; $display("FAIL wr_bready: got %0b want 1", bready); end
    tick(); bvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0) begin
      n_errors++; $display("FAIL wr_rsp: got v=%0b %b %h rdy=%0b want 1 00 0 0", rsp_valid, rsp_resp, rsp_rdata, cmd_ready);
    end
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL wr_period5: got rdy=%0b v=%0b want 1/0", cmd_ready, rsp_valid);
    end
    awready = 1'b0; wready = 1'b0;
  endtask

  task automatic test_read_delayed;
    int stable;
    stable = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (arvalid === 1'b1 && araddr === 32'h20 && arprot === 3'b000) stable++;
      if (i == 3) arready = 1'b1;
      else tick();
    end
    n_checks++;
    if (stable !== 4) begin n_errors++; $display("FAIL rd_araddr_stable: got %0d want 4", stable); end
    tick(); arready = 1'b0;
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      n_errors++; $display("FAIL rd_rready: got ar=%0b r=%0b want 0/1", arvalid, rready);
    end
    rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
    tick(); rvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_resp !== 2'b10) begin
      n_errors++; $display("FAIL rd_rsp: got %0b %h %b want 1 12345678 10", rsp_valid, rsp_rdata, rsp_resp);
    end
    tick();
  endtask

  task automatic test_write_split;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h0000BEEF;
    tick(); cmd_valid = 1'b0; wready = 1'b1;
    tick(); wready = 1'b0;
    n_checks++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      n_errors++; $display("FAIL split_w_first: got %b want 100", {awvalid, wvalid, bready});
    end
    tick(); awready = 1'b1;
    tick(); awready = 1'b0;
    n_checks++;
    if ({awvalid, wvalid, bready} !== 3'b000) begin
      n_errors++; $display("FAIL split_no_early_bready: got %b want 000", {awvalid, wvalid, bready});
    end
    tick();
    n_checks++;
    if (bready !== 1'b1) begin n_errors++; $display("FAIL split_bready: got %0b want 1", bready); end
    bvalid = 1'b1; bresp = 2'b01;
    tick(); bvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b01) begin
      n_errors++; $display("FAIL split_rsp: got %0b %b want 1 01", rsp_valid, rsp_resp);
    end
    tick();
    cmd_valid = 1'b1; cmd_addr = 32'h48;
    tick(); cmd_valid = 1'b0;
    n_checks++;
    if ({awvalid, wvalid, bready} !== 3'b110) begin
      n_errors++; $display("FAIL same_valids: got %b want 110", {awvalid, wvalid, bready});
    end
    awready = 1'b1; wready = 1'b1;
    tick(); awready = 1'b0; wready = 1'b0;
    n_checks++;
    if ({awvalid, wvalid, bready} !== 3'b000) begin
      n_errors++; $display("FAIL same_no_early_bready: got %b want 000", {awvalid, wvalid, bready});
    end
    tick();
    n_checks++;
    if (bready !== 1'b1) begin n_errors++; $display("FAIL same_bready: got %0b want 1", bready); end
    bvalid = 1'b1; bresp = 2'b00;
    tick(); bvalid = 1'b0;
    tick();
  endtask

  task automatic test_rsp_backpressure;
    int bad;
    bad = 0;
    rsp_ready = 1'b0; arready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    tick(); cmd_valid = 1'b0;
    tick(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hA5A55A5A; rresp = 2'b01;
    tick(); rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A55A5A || rsp_resp !== 2'b01 ||
          cmd_ready !== 1'b0 || awvalid !== 1'b0 || arvalid !== 1'b0) bad++;
      if (i != 9) tick();
    end
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || awvalid !== 1'b0 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL bp_release: got rdy=%0b aw=%0b v=%0b want 1 0 0", cmd_ready, awvalid, rsp_valid);
    end
  endtask

`ifdef STATIC_AXIL_TIMEOUT_EN
  task automatic test_timeout;
    int high;
    high = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (arvalid !== 1'b1) break;
      high++;
      tick();
    end
    n_checks++;
    if (high !== 16) begin n_errors++; $display("FAIL to_arvalid_cycles: got %0d want 16", high); end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'h0) begin
      n_errors++; $display("FAIL to_rsp: got %0b %b %h want 1 11 0", rsp_valid, rsp_resp, rsp_rdata);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    tick(); cmd_valid = 1'b0;
    tick(40);
    n_checks++;
    if (arvalid !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL nto_wait: got ar=%0b v=%0b want 1/0", arvalid, rsp_valid);
    end
    arready = 1'b1;
    tick(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h00C0FFEE; rresp = 2'b11;
    tick(); rvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'h00C0FFEE) begin
      n_errors++; $display("FAIL nto_passthrough: got %0b %b %h want 1 11 00c0ffee", rsp_valid, rsp_resp, rsp_rdata);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid_write;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h11112222;
    tick(); cmd_valid = 1'b0;
    n_checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_pre: got aw=%0b w=%0b want 1/1", awvalid, wvalid);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0) begin
      n_errors++; $display("FAIL rstmid_valids: got %b want 0000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      n_errors++; $display("FAIL rstmid_after: got rdy=%0b %b %h want 1 00 0", cmd_ready, rsp_resp, rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_delayed();
    test_write_split();
    test_rsp_backpressure();
`ifdef STATIC_AXIL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
